encode8_3bits_arbiter: RTL and testbench
========================================

# encode8_3bits_arbiter

Round-robin arbiter and 8-to-3 encoder for the eight register/requester lines R0..R7 of the processor datapath. It accepts a one-hot-indexed request vector using the same [0:7] bit ordering as the register enables (bit 0 = R0). It grants exactly one requester at a time, publishes the grant both as a 3-bit register code and as a one-hot vector, and holds the grant until the grantee signals completion or a watchdog expires. It is the encoding counterpart of the 3-to-8 register-select decoder: its W output feeds the XXX/YYY register-select path directly.

## Interface
- MAX_HOLD, 16: maximum cycles a grant may be held without Done; legal range 1..255.
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- En  in  1  arbitration enable; new grants are issued only while En=1.
- Req  in  [0:7]  request lines; Req[i]=1 means Ri requests.
- Done  in  1  grantee releases the current grant; sampled only in GRANT.
- W  out  [2:0]  binary code of the granted requester (000=R0 … 111=R7).
- Gnt  out  [0:7]  one-hot grant; equals the decoder pattern for W while Valid=1, else all zeros.
- Valid  out  1  grant active.
- Err  out  1  sticky watchdog-timeout flag.

## Operation
- State machine: two states.
  - IDLE: Valid=0, Gnt=0.
  - GRANT: Valid=1, Gnt and W stable.
- Internal round-robin pointer Last[2:0] resets to 3'b111, so the first search starts at R0.
- IDLE → GRANT on a rising edge where En=1 and any Req bit is 1.
  - Winner is the first set Req bit at index Last+1, Last+2, … (mod 8, wrap 7→0).
  - W and Gnt are registered with the winner's code; the hold counter clears to 0.
- IDLE with En=0 or Req=0: stay; all outputs hold.
- GRANT → IDLE on an edge with Done=1: Valid, Gnt clear; Last←W; W keeps the last granted code.
- Watchdog:
  - Hold counter (8 bits) increments on each GRANT edge with Done=0.
  - On an edge where counter = MAX_HOLD-1 and Done=0: forced release, same as Done, and Err←1.
- Done and timeout on the same edge: Done wins, Err unchanged.
- In GRANT, changes to Req (including the grantee dropping its request) and to En are ignored; the grant is never revoked except by Done, timeout or Reset.
- Err clears only on Reset.
- Reset (any time, including mid-grant): state=IDLE, W=000, Gnt=0, Valid=0, Err=0, Last=111, counter=0. Outputs change asynchronously, without waiting for a clock edge.

## Timing
- Grant latency: Req/En sampled at edge N; W, Gnt, Valid valid after edge N. The cycle following edge N is the first grant cycle.
- Valid stays high for exactly k cycles if Done is first seen at the k-th GRANT edge, with k ≤ MAX_HOLD.
- Without Done, Valid stays high for exactly MAX_HOLD cycles.
- Release: Valid=0 after the releasing edge. There is at least one IDLE cycle between consecutive grants, so the next grant appears after the following edge.
- Back-to-back requester: a requester holding Req across its own release is re-granted only if no other requester is pending (round-robin).
- Gnt always equals the one-hot decoding of W when Valid=1; Gnt=0 when Valid=0. Never two bits set.

## Test plan
- Reset check: assert Reset with no clock running → W=000, Gnt=00000000, Valid=0, Err=0 immediately. Release Reset, then Req=11111111, En=1 → first grant W=000.
- Basic grant/release: Req bit 2 and bit 5 set (R2, R5), En=1.
  - After one edge: W=010, Gnt=00100000, Valid=1.
  - Done pulse: Valid=0 after that edge.
  - Two edges later: W=101, Gnt=00000100.
- Fairness: Req=11111111 held, Done asserted one cycle into each grant → W sequence 000,001,…,111,000 with no repeats or skips.
- Watchdog: MAX_HOLD=4, Req bit 3 only (R3), Done never asserted → Valid high exactly 4 cycles, then Valid=0 and Err=1. Err stays 1 through later normal grants.
- Enable and priority edge cases:
  - En=0 with Req=10000000 → no grant for 10 cycles.
  - En raised → W=000.
  - En dropped mid-grant → grant held until Done.
  - Done and timeout on the same edge → Err stays 0.
- Reset mid-grant: during a grant of R6 (W=110), pulse Reset asynchronously → Valid and Gnt drop without a clock edge. After Reset releases, Req=01000010 (R1, R6) → R1 granted first, since Last was reset to 111.

Source files
------------

// File: rtl/encode8_3bits_arbiter.sv
// encode8_3bits_arbiter
//   Round-robin arbiter plus 8-to-3 encoder for requester lines R0..R7.
//   One requester is granted at a time. The grant is published as a 3-bit
//   register code (W) and as a one-hot vector (Gnt). It is held until the
//   grantee raises Done or a watchdog of MAX_HOLD cycles expires. A watchdog
//   expiry sets the sticky Err flag.
//
// Parameters
//   MAX_HOLD : longest grant without Done, in cycles (1..255)
//
// Ports
//   Clock  in   rising-edge clock
//   Reset  in   asynchronous, active-high; clears all state
//   En     in   arbitration enable; new grants only while high
//   Req    in   [0:7] request lines, Req[i] = Ri requests
//   Done   in   grantee releases the grant (looked at only while granted)
//   W      out  [2:0] code of the granted requester; keeps last code when idle
//   Gnt    out  [0:7] one-hot grant, all zeros when no grant is active
//   Valid  out  grant active
//   Err    out  sticky watchdog-timeout flag
module encode8_3bits_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       En,
  input  logic [0:7] Req,
  input  logic       Done,
  output logic [2:0] W,
  output logic [0:7] Gnt,
  output logic       Valid,
  output logic       Err
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Counter value at which the final permitted grant cycle is reached.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] last, last_nxt;
  logic [2:0] w_nxt;
  logic [0:7] gnt_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       err_nxt;

  logic [2:0] winner;
  logic [2:0] idx;
  logic       found;

  // Round-robin search: scan Last+1, Last+2, ... wrapping through 3-bit
  // addition. The eighth step lands on Last itself, so the previous grantee
  // is chosen only when nobody else is asking.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!found && Req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    w_nxt     = W;
    gnt_nxt   = Gnt;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    err_nxt   = Err;
    case (state)
      IDLE: begin
        if (En && found) begin
          state_nxt       = GRANT;
          w_nxt           = winner;
          gnt_nxt         = '0;
          gnt_nxt[winner] = 1'b1;
          hold_nxt        = '0;
        end
      end
      GRANT: begin
        // Req and En are deliberately ignored here: a grant ends only by
        // Done or by the watchdog. Done takes precedence, so a release on
        // the expiry cycle itself is not counted as a timeout.
        if (Done || (hold_cnt == HOLD_LAST)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          last_nxt  = W;
          hold_nxt  = '0;
          if (!Done) begin
            err_nxt = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      W        <= 3'b000;
      Gnt      <= '0;
      last     <= 3'b111;
      hold_cnt <= '0;
      Err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      W        <= w_nxt;
      Gnt      <= gnt_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      Err      <= err_nxt;
    end
  end

  assign Valid = (state == GRANT);

endmodule

// File: tb/tb_encode8_3bits_arbiter.sv
module tb_encode8_3bits_arbiter;

  localparam int MAX_HOLD = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       En    = 1'b0;
  logic       Done  = 1'b0;
  logic [0:7] Req   = '0;
  logic [2:0] W;
  logic [0:7] Gnt;
  logic       Valid;
  logic       Err;

  int checks = 0;
  int errors = 0;
  bit clk_run = 1'b0;

  encode8_3bits_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .En(En),
    .Req(Req),
    .Done(Done),
    .W(W),
    .Gnt(Gnt),
    .Valid(Valid),
    .Err(Err)
  );

  always #5 if (clk_run) Clock = ~Clock;

  // Reference model: grant state, who holds it, how many grant cycles have
  // elapsed, round-robin origin and the sticky error.
  bit m_valid = 1'b0;
  int m_w     = 0;
  int m_last  = 7;
  int m_held  = 0;
  bit m_err   = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    bit hit;
    if (Reset) begin
      m_valid = 1'b0;
      m_w     = 0;
      m_last  = 7;
      m_held  = 0;
      m_err   = 1'b0;
    end else if (!m_valid) begin
      if (En && (Req != 8'b0)) begin
        hit = 1'b0;
        for (int k = 1; k <= 8; k++) begin
          if (!hit && Req[(m_last + k) % 8]) begin
            hit = 1'b1;
            m_w = (m_last + k) % 8;
          end
        end
        m_valid = 1'b1;
        m_held  = 1;
      end
    end else begin
      if (Done) begin
        m_valid = 1'b0;
        m_last  = m_w;
      end else if (m_held == MAX_HOLD) begin
        m_valid = 1'b0;
        m_last  = m_w;
        m_err   = 1'b1;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  function automatic logic [0:7] onehot(input int v, input bit on);
    logic [0:7] g;
    g = '0;
    if (on) g[v] = 1'b1;
    return g;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge Clock) begin
    #2;
    if (!Reset) begin
      chk("model_valid", {31'b0, Valid}, {31'b0, m_valid});
      chk("model_w", {29'b0, W}, 32'(m_w));
      chk("model_gnt", {24'b0, Gnt}, {24'b0, onehot(m_w, m_valid)});
      chk("model_err", {31'b0, Err}, {31'b0, m_err});
    end
  end

  task automatic post();
    @(posedge Clock);
    #2;
  endtask

  initial begin
    int n;
    logic [0:7] lit;

    // Asynchronous reset with the clock stopped.
    #1 Reset = 1'b1;
    #1;
    chk("rst_w", {29'b0, W}, 32'd0);
    chk("rst_gnt", {24'b0, Gnt}, 32'd0);
    chk("rst_valid", {31'b0, Valid}, 32'd0);
    chk("rst_err", {31'b0, Err}, 32'd0);
    #1 Reset = 1'b0;
    Req = 8'b11111111;
    En  = 1'b1;
    clk_run = 1'b1;
    post();
    chk("first_w", {29'b0, W}, 32'd0);
    chk("first_valid", {31'b0, Valid}, 32'd1);

    // Basic grant/release with R2 and R5.
    @(negedge Clock); Done = 1'b1; Req = 8'b00100100;
    post();
    chk("rel0_valid", {31'b0, Valid}, 32'd0);
    @(negedge Clock); Done = 1'b0;
    post();
    lit = 8'b00100000;
    chk("basic_w2", {29'b0, W}, 32'b010);
    chk("basic_gnt2", {24'b0, Gnt}, {24'b0, lit});
    chk("basic_valid2", {31'b0, Valid}, 32'd1);
    @(negedge Clock); Done = 1'b1;
    post();
    chk("basic_rel", {31'b0, Valid}, 32'd0);
    @(negedge Clock); Done = 1'b0;
    post();
    lit = 8'b00000100;
    chk("basic_w5", {29'b0, W}, 32'b101);
    chk("basic_gnt5", {24'b0, Gnt}, {24'b0, lit});

    // Fairness: all requesting, each grant released after one cycle.
    @(negedge Clock); Done = 1'b1; Req = 8'b11111111;
    post();
    @(negedge Clock); Done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      post();
      chk("fair_valid", {31'b0, Valid}, 32'd1);
      chk("fair_w", {29'b0, W}, 32'((6 + i) % 8));
      @(negedge Clock); Done = 1'b1;
      if (i == 8) Req = '0;
      post();
      @(negedge Clock); Done = 1'b0;
    end

    // Enable gating: R0 requests but En is low.
    En = 1'b0; Req = 8'b10000000;
    repeat (10) begin
      post();
      chk("en0_valid", {31'b0, Valid}, 32'd0);
    end
    @(negedge Clock); En = 1'b1;
    post();
    chk("en_w", {29'b0, W}, 32'd0);
    chk("en_valid", {31'b0, Valid}, 32'd1);
    @(negedge Clock); En = 1'b0; Req = '0;
    repeat (2) begin
      post();
      chk("hold_valid", {31'b0, Valid}, 32'd1);
      chk("hold_w", {29'b0, W}, 32'd0);
    end
    @(negedge Clock); Done = 1'b1;
    post();
    chk("en_rel", {31'b0, Valid}, 32'd0);

    // Done coinciding with the watchdog expiry: no error.
    @(negedge Clock); Done = 1'b0; En = 1'b1; Req = 8'b00001000;
    post();
    chk("dt_w", {29'b0, W}, 32'b100);
    repeat (3) post();
    chk("dt_still", {31'b0, Valid}, 32'd1);
    @(negedge Clock); Done = 1'b1;
    post();
    chk("dt_valid", {31'b0, Valid}, 32'd0);
    chk("dt_err", {31'b0, Err}, 32'd0);

    // Watchdog: R3 never signals Done.
    @(negedge Clock); Done = 1'b0; Req = 8'b00010000;
    post();
    chk("wd_w", {29'b0, W}, 32'b011);
    n = 1;
    for (int t = 0; t < 20; t++) begin
      post();
      if (!Valid) break;
      n++;
    end
    chk("wd_cycles", 32'(n), 32'd4);
    chk("wd_err", {31'b0, Err}, 32'd1);
    post();
    chk("wd_regrant", {31'b0, Valid}, 32'd1);
    @(negedge Clock); Done = 1'b1; Req = '0;
    post();
    chk("wd_err_sticky", {31'b0, Err}, 32'd1);
    @(negedge Clock); Done = 1'b0;

    // Randomized traffic checked by the model.
    repeat (300) begin
      @(negedge Clock);
      Req  = 8'($urandom);
      En   = ($urandom_range(0, 3) != 0);
      Done = ($urandom_range(0, 2) == 0);
    end
    @(negedge Clock); Req = '0; Done = 1'b1;
    post();
    post();

    // Reset in the middle of an R6 grant.
    @(negedge Clock); Done = 1'b0; En = 1'b1; Req = 8'b00000010;
    post();
    chk("r6_w", {29'b0, W}, 32'b110);
    chk("r6_valid", {31'b0, Valid}, 32'd1);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("mr_valid", {31'b0, Valid}, 32'd0);
    chk("mr_gnt", {24'b0, Gnt}, 32'd0);
    chk("mr_w", {29'b0, W}, 32'd0);
    chk("mr_err", {31'b0, Err}, 32'd0);
    #1 Reset = 1'b0;
    Req = 8'b01000010;
    post();
    chk("mr_first_w", {29'b0, W}, 32'b001);
    chk("mr_first_valid", {31'b0, Valid}, 32'd1);

    @(negedge Clock); Req = '0; Done = 1'b1;
    post();
    post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
